// File: rtl/morse_symbol_decoder.sv
// rtl/morse_symbol_decoder.sv - collects dot/dash symbols into a letter and emits its ASCII code
module morse_symbol_decoder #(
    parameter int MAX_ELEMS  = 5,
    parameter int GAP_CYCLES = 0,
    parameter int GAP_W      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] dotOrDash,
    input  logic       char_ready,
    output logic       char_valid,
    output logic [7:0] char_data,
    output logic [2:0] elem_count,
    output logic       err_overflow,
    output logic       err_drop
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [2:0]       MAX_CNT  = 3'(MAX_ELEMS);
    // Commit fires on the idle edge that would bring the counter up to GAP_CYCLES.
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

    state_t           state_q, state_d;
    logic [1:0]       prev_q;
    logic [4:0]       pat_q;
    logic [2:0]       cnt_q;
    logic             inv_q;
    logic [GAP_W-1:0] gap_q;

    logic             ev, elem_ev, send_ev, gap_hit, commit;
    logic [7:0]       dec_char;

    assign ev         = (dotOrDash != 2'b00) && (dotOrDash != prev_q);
    assign elem_ev    = ev && ((dotOrDash == 2'b01) || (dotOrDash == 2'b10));
    assign send_ev    = ev && (dotOrDash == 2'b11);
    assign gap_hit    = (GAP_CYCLES != 0) && (cnt_q != 3'd0) && !elem_ev && (gap_q == GAP_LAST);
    assign commit     = (send_ev || gap_hit) && (state_q == COLLECT);
    assign elem_count = cnt_q;

    // Re-order the stored elements so the first element is the MSB of the key.
    function automatic logic [7:0] decode(input logic [4:0] pat, input logic [2:0] n,
                                          input logic inv);
        logic [4:0] nat;
        logic [7:0] ch;
        nat = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(n)) nat = {nat[3:0], pat[k]};
        end
        case ({n, nat})
            {3'd1, 5'b00000}: ch = 8'h45;  // E
            {3'd1, 5'b00001}: ch = 8'h54;  // T
            {3'd2, 5'b00000}: ch = 8'h49;  // I
            {3'd2, 5'b00001}: ch = 8'h41;  // A
            {3'd2, 5'b00010}: ch = 8'h4E;  // N
            {3'd2, 5'b00011}: ch = 8'h4D;  // M
            {3'd3, 5'b00000}: ch = 8'h53;  // S
            {3'd3, 5'b00001}: ch = 8'h55;  // U
            {3'd3, 5'b00010}: ch = 8'h52;  // R
            {3'd3, 5'b00011}: ch = 8'h57;  // W
            {3'd3, 5'b00100}: ch = 8'h44;  // D
            {3'd3, 5'b00101}: ch = 8'h4B;  // K
            {3'd3, 5'b00110}: ch = 8'h47;  // G
            {3'd3, 5'b00111}: ch = 8'h4F;  // O
            {3'd4, 5'b00000}: ch = 8'h48;  // H
            {3'd4, 5'b00001}: ch = 8'h56;  // V
            {3'd4, 5'b00010}: ch = 8'h46;  // F
            {3'd4, 5'b00100}: ch = 8'h4C;  // L
            {3'd4, 5'b00110}: ch = 8'h50;  // P
            {3'd4, 5'b00111}: ch = 8'h4A;  // J
            {3'd4, 5'b01000}: ch = 8'h42;  // B
            {3'd4, 5'b01001}: ch = 8'h58;  // X
            {3'd4, 5'b01010}: ch = 8'h43;  // C
            {3'd4, 5'b01011}: ch = 8'h59;  // Y
            {3'd4, 5'b01100}: ch = 8'h5A;  // Z
            {3'd4, 5'b01101}: ch = 8'h51;  // Q
            {3'd5, 5'b11111}: ch = 8'h30;
            {3'd5, 5'b01111}: ch = 8'h31;
            {3'd5, 5'b00111}: ch = 8'h32;
            {3'd5, 5'b00011}: ch = 8'h33;
            {3'd5, 5'b00001}: ch = 8'h34;
            {3'd5, 5'b00000}: ch = 8'h35;
            {3'd5, 5'b10000}: ch = 8'h36;
            {3'd5, 5'b11000}: ch = 8'h37;
            {3'd5, 5'b11100}: ch = 8'h38;
            {3'd5, 5'b11110}: ch = 8'h39;
            default:          ch = 8'h3F;
        endcase
        return inv ? 8'h3F : ch;
    endfunction

    assign dec_char = decode(pat_q, cnt_q, inv_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (elem_ev) state_d = COLLECT;
            COLLECT: if (commit)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q       <= 2'b00;
            pat_q        <= '0;
            cnt_q        <= '0;
            inv_q        <= 1'b0;
            gap_q        <= '0;
            err_overflow <= 1'b0;
        end else begin
            prev_q       <= dotOrDash;
            err_overflow <= 1'b0;
            if (commit) begin
                pat_q <= '0;
                cnt_q <= '0;
                inv_q <= 1'b0;
                gap_q <= '0;
            end else if (elem_ev) begin
                gap_q <= '0;
                if (cnt_q < MAX_CNT) begin
                    pat_q[cnt_q] <= dotOrDash[1];
                    cnt_q        <= cnt_q + 3'd1;
                end else begin
                    inv_q        <= 1'b1;
                    err_overflow <= !inv_q;
                end
            end else if ((cnt_q != 3'd0) && (gap_q != {GAP_W{1'b1}})) begin
                gap_q <= gap_q + 1'b1;
            end
        end
    end

    // One-entry holding stage toward the display/UART side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            char_valid <= 1'b0;
            char_data  <= 8'h00;
            err_drop   <= 1'b0;
        end else begin
            err_drop <= 1'b0;
            if (commit) begin
                if (!char_valid || char_ready) begin
                    char_valid <= 1'b1;
                    char_data  <= dec_char;
                end else begin
                    err_drop <= 1'b1;
                end
            end else if (char_valid && char_ready) begin
                char_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// tb/tb_morse_symbol_decoder.sv - directed scoreboard bench for morse_symbol_decoder
module tb_morse_symbol_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dotOrDash;
    logic       char_ready;
    logic       char_valid;
    logic [7:0] char_data;
    logic [2:0] elem_count;
    logic       err_overflow;
    logic       err_drop;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_ovf   = 0;
    int         n_drop  = 0;
    int         ovf0, drop0;
    logic [7:0] exp_q[$];

    morse_symbol_decoder #(.MAX_ELEMS(5), .GAP_CYCLES(8), .GAP_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .dotOrDash   (dotOrDash),
        .char_ready  (char_ready),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .elem_count  (elem_count),
        .err_overflow(err_overflow),
        .err_drop    (err_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sym(input logic [1:0] c);
        dotOrDash = c;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every char seen leaving on a handshake must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (err_overflow) n_ovf++;
            if (err_drop)     n_drop++;
            if (char_valid && char_ready) begin
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_char: observed %0h expected none", char_data);
                end
                if (exp_q.size() != 0) chk("char_out", char_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        dotOrDash  = 2'b00;
        char_ready = 1'b0;
        #3;
        chk("rst_valid", char_valid, 0);
        chk("rst_data", char_data, 0);
        chk("rst_count", elem_count, 0);
        chk("rst_ovf", err_overflow, 0);
        chk("rst_drop", err_drop, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        char_ready = 1'b1;

        // A with held send
        sym(2'b01); chk("t1_cnt1", elem_count, 1);
        sym(2'b00);
        sym(2'b10); chk("t1_cnt2", elem_count, 2);
        sym(2'b00);
        exp_q.push_back(8'h41);
        sym(2'b11); chk("t1_cnt0", elem_count, 0); chk("t1_valid", char_valid, 1);
        chk("t1_data", char_data, 8'h41);
        sym(2'b11); chk("t1_once", char_valid, 0);
        sym(2'b11); sym(2'b11); chk("t1_held", char_valid, 0);
        sym(2'b00);

        // S then 0
        for (int i = 0; i < 3; i++) begin sym(2'b01); sym(2'b00); end
        exp_q.push_back(8'h53);
        sym(2'b11); chk("t2_S", char_data, 8'h53);
        for (int i = 0; i < 4; i++) begin sym(2'b00); chk("t2_idle", char_valid, 0); end
        for (int i = 0; i < 5; i++) begin sym(2'b10); sym(2'b00); end
        chk("t2_cnt5", elem_count, 5);
        exp_q.push_back(8'h30);
        sym(2'b11); chk("t2_0", char_data, 8'h30);
        sym(2'b00);

        // overflow
        ovf0 = n_ovf;
        for (int i = 0; i < 6; i++) begin
            sym(2'b10);
            if (i == 5) begin
                chk("t3_ovf_pulse", err_overflow, 1);
                chk("t3_cnt5", elem_count, 5);
            end
            sym(2'b00);
        end
        chk("t3_ovf_gone", err_overflow, 0);
        chk("t3_ovf_once", n_ovf - ovf0, 1);
        exp_q.push_back(8'h3F);
        sym(2'b11); chk("t3_q", char_data, 8'h3F);
        sym(2'b00);

        // gap auto-commit after 8 idle cycles
        exp_q.push_back(8'h4E);
        sym(2'b10); sym(2'b00); sym(2'b01);
        repeat (7) sym(2'b00);
        chk("t4_not_yet", char_valid, 0);
        chk("t4_cnt2", elem_count, 2);
        sym(2'b00);
        chk("t4_valid", char_valid, 1);
        chk("t4_N", char_data, 8'h4E);
        chk("t4_cnt0", elem_count, 0);
        sym(2'b00); sym(2'b11); sym(2'b11); sym(2'b00);
        chk("t4_empty_send", char_valid, 0);

        // drop while occupied
        char_ready = 1'b0;
        exp_q.push_back(8'h45);
        sym(2'b01); sym(2'b00); sym(2'b11);
        chk("t5_valid", char_valid, 1); chk("t5_E", char_data, 8'h45);
        sym(2'b00); sym(2'b10); sym(2'b00);
        drop0 = n_drop;
        sym(2'b11);
        chk("t5_drop_pulse", err_drop, 1);
        chk("t5_held", char_data, 8'h45);
        chk("t5_cnt0", elem_count, 0);
        sym(2'b00);
        chk("t5_drop_gone", err_drop, 0);
        chk("t5_drop_once", n_drop - drop0, 1);
        char_ready = 1'b1;
        sym(2'b00); chk("t5_accepted", char_valid, 0);
        sym(2'b00); chk("t5_no_T", char_valid, 0);

        // accept and commit on the same edge
        char_ready = 1'b0;
        exp_q.push_back(8'h45);
        sym(2'b01); sym(2'b00); sym(2'b11); sym(2'b00);
        sym(2'b10); sym(2'b00);
        exp_q.push_back(8'h54);
        char_ready = 1'b1;
        sym(2'b11);
        chk("t5_reload_valid", char_valid, 1);
        chk("t5_reload_T", char_data, 8'h54);
        sym(2'b00); chk("t5_reload_done", char_valid, 0);

        // async reset mid-character with a held output
        char_ready = 1'b0;
        sym(2'b01); sym(2'b00); sym(2'b11); sym(2'b00);
        sym(2'b01); sym(2'b00); sym(2'b10); sym(2'b00); sym(2'b01);
        chk("t6_cnt3", elem_count, 3);
        chk("t6_valid", char_valid, 1);
        #2 rst_n = 1'b0;
        dotOrDash = 2'b00;
        #1;
        chk("t6_rst_valid", char_valid, 0);
        chk("t6_rst_data", char_data, 0);
        chk("t6_rst_count", elem_count, 0);
        chk("t6_rst_ovf", err_overflow, 0);
        chk("t6_rst_drop", err_drop, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        char_ready = 1'b1;
        exp_q.push_back(8'h45);
        sym(2'b01); sym(2'b00); sym(2'b11);
        chk("t6_E", char_data, 8'h45);
        sym(2'b00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_symbol_decoder.md
Name: morse_symbol_decoder

Overview:
Downstream consumer of the button-timing classifier's 2-bit symbol stream (00 wait, 01 dot, 10 dash, 11 send). Collects dots and dashes into a letter buffer. Commits the buffer on a send event or, optionally, after an inter-letter silence timeout. Decodes the buffer to 8-bit ASCII and presents it on a valid/ready output toward the display/UART stage.

Parameters:
MAX_ELEMS, 5, maximum elements per character (covers A-Z and 0-9); fixed at 5 for the lookup table.
GAP_CYCLES, 0, idle cycles with a non-empty buffer before an automatic commit; 0 disables auto-commit.
GAP_W, 16, width of the gap counter; GAP_CYCLES must be less than 2^GAP_W.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
dotOrDash  input  2  symbol code from the timing classifier: 00 wait, 01 dot, 10 dash, 11 send.
char_ready  input  1  downstream accepts char_data when high with char_valid.
char_valid  output  1  char_data holds an undelivered character.
char_data  output  8  ASCII code of the decoded character.
elem_count  output  3  number of elements currently buffered (0..5).
err_overflow  output  1  one-cycle pulse: a 6th element arrived.
err_drop  output  1  one-cycle pulse: a commit was discarded because the output was still occupied.

Behaviour:
- Reset (async, rst_n=0): char_valid=0, char_data=8'h00, elem_count=0, err_overflow=0, err_drop=0; pattern buffer, invalid flag, gap counter and previous-code register are all cleared. Reset mid-character discards the partial buffer.
- Event detection:
  - Register the previous dotOrDash value.
  - An event is a non-00 code that differs from the previous code.
  - A held 11 therefore commits exactly once.
  - Back-to-back identical dots are always separated by 00 from the upstream stage.
- Pattern storage: 5-bit pattern, element k stored in bit k (0=dot, 1=dash), plus the count.
- Dot/dash event, count<5: write bit[count], count+1, gap counter cleared.
- Dot/dash event, count==5: count stays 5, invalid flag set, err_overflow pulses on the first overflow of the character only.
- Commit sources:
  - a send event;
  - GAP_CYCLES!=0, count>0, and the gap counter reaches GAP_CYCLES.
  - The gap counter increments each cycle with count>0 and no event; it saturates and is not wrap-sensitive.
- Commit with count==0: ignored; no output and no error.
- Commit decode:
  - Standard ITU Morse for A-Z (uppercase, 0x41-0x5A) and 0-9 (0x30-0x39).
  - Invalid flag set, or a pattern not in the table: emits '?' (0x3F).
- Commit latency: a commit sampled at edge N gives char_valid=1 and char_data valid after edge N; buffer, count, invalid flag and gap counter are cleared at the same edge.
- Output handshake:
  - char_valid holds, and char_data is stable, until an edge where char_valid && char_ready.
  - char_valid then drops, unless a commit occurs on that same edge, in which case the new char loads and char_valid stays 1.
- Commit while char_valid=1 and char_ready=0: the new character is discarded, the buffer is cleared, err_drop pulses 1 cycle, and the held char_data is unchanged.
- Element event and gap timeout on the same edge: the element wins; it is stored and the gap counter is cleared, with no commit.
- Send event and dot/dash cannot coincide (single 2-bit code).
- Control structure: IDLE (count==0) -> COLLECT on the first element; COLLECT -> IDLE on commit. The output register is an independent one-entry holding stage.

Test Plan:
1. Reset, then dot, 00, dash, 00, 11 held 4 cycles, char_ready=1 -> one char_valid pulse, char_data=0x41 ('A'); elem_count 0,1,2,0.
2. Three dots, send; then dash x5, send -> 0x53 ('S') then 0x30 ('0'); char_valid stays 0 across the idle gap.
3. Six dashes then send -> err_overflow pulses once (at the 6th), elem_count=5, char_data=0x3F.
4. GAP_CYCLES=8: dash, dot, then 00 for 8 cycles -> auto-commit, char_data=0x4E ('N'); then 11 with an empty buffer -> no output.
5. char_ready=0: commit 'E' (dot) then commit 'T' (dash) -> char_data stays 0x45 and err_drop pulses; raise char_ready -> 'E' accepted, no 'T' emitted. Also: acceptance and a new commit on the same edge -> char_valid remains 1 with the new char.
6. Assert rst_n=0 asynchronously mid-character (count=3) and with char_valid=1 -> all outputs zero immediately; after release, 'E' decodes correctly.
